// File: rtl/ifid_skid_buffer.sv
// IF/ID pipeline register as a two-entry skid buffer with valid/ready on both sides.
// Adds synchronous flush, NOP bubble output and a saturating stall-cycle counter.
module ifid_skid_buffer #(
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          INSTR_W   = 16,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = {INSTR_W{1'b0}},
    parameter logic [ADDR_W-1:0]    RESET_PC  = {ADDR_W{1'b0}},
    parameter int unsigned          CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cycles
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    localparam entry_t ENTRY_RST = '{pc: RESET_PC, instr: NOP_INSTR};

    state_e             state_q, state_d;
    entry_t             head_q, head_d;
    entry_t             skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic   can_push;
    logic   has_head;
    logic   push;
    logic   pop;
    entry_t in_entry;

    // Handshake qualifiers come from registered state only.
    assign can_push = (state_q != FULL);
    assign has_head = (state_q != EMPTY);
    assign push     = in_valid & can_push;
    assign pop      = has_head & out_ready;
    assign in_entry = '{pc: in_pc, instr: in_instr};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d = FULL;
                    end else if (pop && !push) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        if (!flush) begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d = in_entry;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push) begin
                        skid_d = in_entry;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d = skid_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (has_head && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        in_ready     = can_push;
        out_valid    = has_head;
        out_pc       = head_q.pc;
        out_instr    = has_head ? head_q.instr : NOP_INSTR;
        stall_cycles = stall_q;
        unique case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: doc/ifid_skid_buffer.md
Name: ifid_skid_buffer

Overview:
Parametrised successor to the fixed 16-bit IF/ID pipeline register. It sits between fetch and decode and carries a PC/instruction pair. A two-entry skid buffer with valid/ready handshakes on both sides replaces the single stall input, so back-pressure is fully registered. Adds synchronous flush, NOP bubble output when empty, and a saturating stall-cycle counter for performance monitoring.

Parameters:
ADDR_W, 16, PC width in bits.
INSTR_W, 16, instruction width in bits.
NOP_INSTR, {INSTR_W{1'b0}}, instruction value driven on out_instr whenever out_valid=0.
RESET_PC, {ADDR_W{1'b0}}, value of out_pc and of both entry PC fields after reset.
CNT_W, 8, width of the stall-cycle counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  fetch presents a valid PC/instruction pair.
in_ready  out  1  buffer accepts the pair this cycle.
in_pc  in  ADDR_W  fetched PC.
in_instr  in  INSTR_W  fetched instruction.
flush  in  1  synchronous discard of all held and incoming entries (branch or jump redirect).
out_valid  out  1  decode-side pair valid.
out_ready  in  1  decode consumes the pair this cycle.
out_pc  out  ADDR_W  PC of the head entry.
out_instr  out  INSTR_W  instruction of the head entry; NOP_INSTR when out_valid=0.
occupancy  out  2  number of held entries, 0 to 2.
stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Events: push = in_valid & in_ready; pop = out_valid & out_ready.
- State: head register (drives outputs), skid register, state in {EMPTY, ONE, FULL}.
- Derived outputs: occupancy = 0/1/2 for EMPTY/ONE/FULL; out_valid = (state != EMPTY); in_ready = (state != FULL). All outputs are functions of registers only; there is no combinational path from any input to any output.
- Transitions (when flush=0):
  - EMPTY:
    - push: head <= in, go to ONE.
    - else: stay.
  - ONE:
    - push & pop: head <= in, stay ONE.
    - push & !pop: skid <= in, go to FULL.
    - pop & !push: go to EMPTY.
    - else: hold.
  - FULL (in_ready=0, so no push):
    - pop: head <= skid, go to ONE.
    - else: hold.
- Latency: a pair pushed into EMPTY appears on the outputs the next cycle. Strict FIFO order; no entry is ever dropped or duplicated without flush.
- Data holds: out_pc and out_instr are stable while out_valid=1 and out_ready=0.
- Empty output: when state is EMPTY, out_instr = NOP_INSTR and out_pc holds its last head value (RESET_PC after reset).
- Flush (highest priority after reset):
  - Next state is EMPTY regardless of push or pop.
  - An input presented in the same cycle is discarded, even if in_ready=1.
  - A pop in the same cycle still counts as consumed by decode.
  - in_ready=1 from the following cycle.
- Stall counter:
  - Increments on every cycle with out_valid & !out_ready, including the flush cycle.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Unaffected by flush; cleared only by reset.
- Reset, including assertion mid-transfer, immediately forces:
  - state EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - out_pc=RESET_PC, out_instr=NOP_INSTR.
  - head and skid contents to RESET_PC/NOP_INSTR.
  - stall_cycles=0.
- Width rules: ports take their widths exactly from the parameters; no truncation or extension inside the block.

Test Plan:
- Reset then stream: in_valid=1 with PCs 0x0000,0x0002,0x0004 and out_ready=1 -> out_pc shows 0x0000,0x0002,0x0004 on consecutive cycles, one cycle after each push; occupancy stays 1; in_ready stays 1.
- Back-pressure: out_ready=0 while pushing 0x0010 (instr 0x1234) then 0x0012 (0x5678) -> occupancy 2, in_ready=0, head holds 0x0010/0x1234. Raise out_ready -> outputs 0x0012/0x5678 next cycle, then out_valid=0 and out_instr=NOP_INSTR.
- Flush while FULL with in_valid=1 (PC 0x0020) -> next cycle occupancy=0, out_valid=0, in_ready=1; PC 0x0020 never appears on out_pc.
- Stall counter with CNT_W=2: hold out_ready=0 with out_valid=1 for 5 cycles -> stall_cycles counts 1,2,3,3,3; flush leaves it at 3; reset clears it to 0.
- Async reset mid-cycle while FULL -> outputs go to reset values before the next clock edge; first push after release appears on the outputs one cycle later.
- Parametrisation with ADDR_W=32, INSTR_W=32, NOP_INSTR=0x00000013 -> all 32 bits pass through unchanged; out_instr=0x00000013 whenever the buffer is empty.
